// File: rtl/input_capture.sv
// input_capture: debounced pushbutton handshake that captures the slide switches
// for a CPU input instruction, stalling the CPU until a fresh press arrives.
module input_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          SIGN_EXT        = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button,
    input  logic [17:0] switches,
    input  logic        in_req,
    output logic        stall,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        btn_pressed
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        DONE         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        btn_q;
    logic        btn_d;
    logic        btn_dly_q;
    state_e      state_q;
    state_e      state_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        valid_q;

    logic        btn_differs;
    logic        press_edge;
    logic        capture;
    logic [31:0] switches_ext;

    // The raw button is active-low, so the synchronized level is inverted before
    // comparing it with the active-high debounced level.
    assign btn_differs  = (~sync2_q) != btn_q;
    assign press_edge   = btn_q & ~btn_dly_q;
    assign switches_ext = {{14{SIGN_EXT & switches[17]}}, switches};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = '0;
        btn_d = btn_q;
        if (btn_differs) begin
            if (cnt_q == CNT_LAST) begin
                btn_d = ~btn_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                // Abort takes priority over a press arriving on the same edge.
                if (!in_req) begin
                    state_d = IDLE;
                end else if (press_edge) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            DONE: begin
                state_d = btn_q ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!btn_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_d = capture ? switches_ext : data_q;

    always_comb begin
        stall = reset & in_req & ((state_q == IDLE) | (state_q == WAIT_PRESS));
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            btn_dly_q <= 1'b0;
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            btn_dly_q <= btn_q;
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= (state_d == DONE);
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign btn_pressed = btn_q;

endmodule
